ins_enc: RTL

Instruction encoder/loader, the producer for the Lab-6 instruction decoder. Accepts one instruction as separate fields (opcode, op, register numbers, shift, signed immediate) over a valid/ready handshake, checks legality and immediate range, and packs them into the 16-bit decoder format. Each legal word is written to instruction memory at an auto-incrementing address. Used by the test harness and boot path to fill program memory before the CPU runs.

---
 rtl/ins_enc.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ins_enc.sv
// Instruction encoder/loader: packs a field bundle into the 16-bit decoder word
// and writes each legal word to instruction memory at an auto-incrementing address.
module ins_enc #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        opcode,
  input  logic [1:0]        op,
  input  logic [2:0]        rn,
  input  logic [2:0]        rd,
  input  logic [2:0]        rm,
  input  logic [1:0]        shift,
  input  logic [15:0]       imm,
  input  logic              restart,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_ILLEG = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W:0]     count_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [15:0]         wdata_q;
  logic                err_q;
  logic [1:0]          err_code_q;

  logic                enc_legal;
  logic                enc_range_ok;
  logic [15:0]         enc_word;
  logic                imm8_ok;
  logic                imm5_ok;
  logic                accept;
  logic                bundle_ok;
  logic                last_addr;

  // Handshake: a bundle transfers on a rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE outside reset, and restart suppresses the transfer.
  assign in_ready  = (state_q == S_IDLE) && !reset;
  assign accept    = in_valid && in_ready && !restart;
  assign bundle_ok = enc_legal && enc_range_ok;
  assign last_addr = (addr_q == {ADDR_W{1'b1}});

  // Sign-extension check over the full 16-bit immediate: upper bits all equal.
  assign imm8_ok = (&imm[15:7]) || (~|imm[15:7]);
  assign imm5_ok = (&imm[15:4]) || (~|imm[15:4]);

  // Field packing; unused fields are forced to zero per instruction class.
  always_comb begin
    enc_legal    = 1'b1;
    enc_range_ok = 1'b1;
    enc_word     = 16'h0000;
    case ({opcode, op})
      5'b110_10: begin
        enc_word     = {3'b110, 2'b10, rn, imm[7:0]};
        enc_range_ok = imm8_ok;
      end
      5'b110_00: enc_word = {3'b110, 2'b00, 3'b000, rd, shift, rm};
      5'b101_00,
      5'b101_10: enc_word = {3'b101, op, rn, rd, shift, rm};
      5'b101_01: enc_word = {3'b101, 2'b01, rn, 3'b000, shift, rm};
      5'b101_11: enc_word = {3'b101, 2'b11, 3'b000, rd, shift, rm};
      5'b011_00,
      5'b100_00: begin
        enc_word     = {opcode, 2'b00, rn, rd, imm[4:0]};
        enc_range_ok = imm5_ok;
      end
      default: begin
        enc_legal    = 1'b0;
        enc_range_ok = 1'b1;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; restart always returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && bundle_ok) state_d = S_WRITE;
      S_WRITE: state_d = last_addr ? S_FULL : S_IDLE;
      S_FULL:  state_d = S_FULL;
      default: state_d = S_IDLE;
    endcase
    if (restart) state_d = S_IDLE;
  end

  // Datapath: address/count, captured write word, sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      count_q    <= '0;
      wr_addr_q  <= '0;
      wdata_q    <= 16'h0000;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      if (accept && bundle_ok) begin
        wr_addr_q <= addr_q;
        wdata_q   <= enc_word;
      end
      if (restart) begin
        addr_q     <= '0;
        count_q    <= '0;
        err_q      <= 1'b0;
        err_code_q <= ERR_NONE;
      end else begin
        if (state_q == S_WRITE) begin
          addr_q  <= addr_q + ADDR_W'(1);
          count_q <= count_q + (ADDR_W + 1)'(1);
        end
        // First error wins; an illegal opcode/op never reaches the range check
        if (accept && !bundle_ok) begin
          err_q <= 1'b1;
          if (err_code_q == ERR_NONE) begin
            err_code_q <= enc_legal ? ERR_RANGE : ERR_ILLEG;
          end
        end
      end
    end
  end

  // Outputs
  always_comb begin
    mem_write = (state_q == S_WRITE);
    full      = (state_q == S_FULL);
    mem_addr  = wr_addr_q;
    mem_wdata = wdata_q;
    count     = count_q;
    err       = err_q;
    err_code  = err_code_q;
    dbg_state = state_q;
  end

endmodule
